store_merge_rmw: RTL and testbench

- Sequential store-merge unit that performs sub-word stores (byte/halfword, and word when DATA_W=64) as read-modify-write against word-addressed data memory.
- Sits between the datapath store path and data memory.
- Generalises the low-lane-only halfword/byte overwrite: supports any lane offset, parametrised data width and read latency, checks alignment, and uses a valid/ready handshake.

---
 rtl/store_merge_rmw_if.sv | 30 +++
 rtl/store_merge_rmw.sv | 208 ++++++++++++++++++++
 tb/tb_store_merge_rmw.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/store_merge_rmw_if.sv
// Store-merge bus: store request handshake, memory port and status pulses.
// The bench or the datapath uses the master side. The store-merge unit uses the slave side.
interface store_merge_rmw_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic [1:0]        req_size;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_wdata;
  logic              done;
  logic              err;
  logic              busy;

  modport master (
    output req_valid, req_addr, req_data, req_size, mem_rdata,
    input  req_ready, mem_addr, mem_rd, mem_wr, mem_wdata, done, err, busy
  );

  modport slave (
    input  req_valid, req_addr, req_data, req_size, mem_rdata,
    output req_ready, mem_addr, mem_rd, mem_wr, mem_wdata, done, err, busy
  );
endinterface

// File: rtl/store_merge_rmw.sv
// Sub-word store unit. It merges byte, halfword or word store data into a memory
// word by read-modify-write. A store that covers the whole word writes directly.
// Misaligned or illegal requests are rejected with err and make no memory access.
module store_merge_rmw #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  store_merge_rmw_if.slave bus
);
  localparam int LANES = DATA_W / 8;
  localparam int L     = $clog2(LANES);
  localparam int CW    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam bit WIDE  = (DATA_W == 64);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  state_t            state_r, state_s;
  logic [CW-1:0]     wait_cnt_r;
  logic [DATA_W-1:0] data_r;
  logic [L-1:0]      lane_r;
  logic [1:0]        size_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic              rd_r, wr_r, done_r, err_r, busy_r, ready_r;
  logic              rd_s, wr_s, done_s, err_s, busy_s, ready_s;
  logic              accept_s, illegal_s, full_s;
  logic [L-1:0]      lane_s;

  // Replace lanes k..k+n-1 of the old word with the low n bytes of the store data.
  function automatic logic [DATA_W-1:0] merge_lanes(
    input logic [DATA_W-1:0] old_word,
    input logic [DATA_W-1:0] st_data,
    input logic [L-1:0]      k,
    input logic [1:0]        size
  );
    logic [DATA_W-1:0] res;
    int n;
    case (size)
      2'b00:   n = 4;
      2'b01:   n = 2;
      2'b10:   n = 1;
      default: n = LANES;
    endcase
    res = old_word;
    for (int i = 0; i < LANES; i++) begin
      if ((i >= int'(k)) && (i < int'(k) + n)) begin
        res[8*i +: 8] = st_data[8*(i - int'(k)) +: 8];
      end else begin
        res[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    return res;
  endfunction

  assign accept_s = bus.req_valid && ready_r;
  assign lane_s   = bus.req_addr[L-1:0];

  // Classify the incoming request: alignment or size violation, and whole-word coverage.
  always_comb begin
    illegal_s = 1'b1;
    full_s    = 1'b0;
    case (bus.req_size)
      2'b00: begin
        illegal_s = (lane_s[1:0] != 2'b00);
        full_s    = !WIDE;
      end
      2'b01: begin
        illegal_s = lane_s[0];
        full_s    = 1'b0;
      end
      2'b10: begin
        illegal_s = 1'b0;
        full_s    = 1'b0;
      end
      2'b11: begin
        illegal_s = !WIDE || (lane_s != {L{1'b0}});
        full_s    = WIDE;
      end
      default: begin
        illegal_s = 1'b1;
        full_s    = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          if (illegal_s) begin
            state_s = S_ERR;
          end else if (full_s) begin
            state_s = S_WRITE;
          end else begin
            state_s = S_READ;
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_READ:  state_s = S_WAIT;
      S_WAIT: begin
        if (wait_cnt_r == {CW{1'b0}}) begin
          state_s = S_WRITE;
        end else begin
          state_s = S_WAIT;
        end
      end
      S_WRITE: state_s = S_DONE;
      S_DONE:  state_s = S_IDLE;
      S_ERR:   state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // Output decode from the upcoming state, so the strobes line up with their state.
  always_comb begin
    rd_s    = (state_s == S_READ);
    wr_s    = (state_s == S_WRITE);
    done_s  = (state_s == S_DONE);
    err_s   = (state_s == S_ERR);
    busy_s  = (state_s != S_IDLE);
    ready_s = (state_s == S_IDLE);
  end

  // Registered strobes and status.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_r    <= 1'b0;
      wr_r    <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
      busy_r  <= 1'b0;
      ready_r <= 1'b0;
    end else begin
      rd_r    <= rd_s;
      wr_r    <= wr_s;
      done_r  <= done_s;
      err_r   <= err_s;
      busy_r  <= busy_s;
      ready_r <= ready_s;
    end
  end

  // Request capture, read-latency counting and merged write-data generation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_r     <= {DATA_W{1'b0}};
      lane_r     <= {L{1'b0}};
      size_r     <= 2'b00;
      mem_addr_r <= {ADDR_W{1'b0}};
      wdata_r    <= {DATA_W{1'b0}};
      wait_cnt_r <= {CW{1'b0}};
    end else begin
      if (accept_s) begin
        data_r     <= bus.req_data;
        lane_r     <= lane_s;
        size_r     <= bus.req_size;
        mem_addr_r <= {bus.req_addr[ADDR_W-1:L], {L{1'b0}}};
        if (full_s && !illegal_s) begin
          wdata_r <= bus.req_data;
        end else begin
          wdata_r <= wdata_r;
        end
      end else if (state_r == S_READ) begin
        wait_cnt_r <= CW'(RD_LAT - 1);
      end else if (state_r == S_WAIT) begin
        if (wait_cnt_r == {CW{1'b0}}) begin
          wdata_r <= merge_lanes(bus.mem_rdata, data_r, lane_r, size_r);
        end else begin
          wait_cnt_r <= wait_cnt_r - CW'(1'b1);
        end
      end else begin
        wait_cnt_r <= wait_cnt_r;
      end
    end
  end

  assign bus.req_ready = ready_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_rd    = rd_r;
  assign bus.mem_wr    = wr_r;
  assign bus.mem_wdata = wdata_r;
  assign bus.done      = done_r;
  assign bus.err       = err_r;
  assign bus.busy      = busy_r;
endmodule

// File: tb/tb_store_merge_rmw.sv
// Randomised bench for store_merge_rmw. It builds three configurations:
// 32-bit/RD_LAT=1, 32-bit/RD_LAT=3 and 64-bit/RD_LAT=1. A latency-accurate memory
// returns data only in the cycle the unit should capture it. A mask-arithmetic
// reference memory predicts every write and every strobe timing.
module tb_store_merge_rmw;
  logic        clk;
  logic        reset;
  int          sel;
  int          lat;
  int          wsel;
  int          shamt;
  logic        req_valid;
  logic [31:0] req_addr;
  logic [63:0] req_data;
  logic [1:0]  req_size;
  logic        o_ready, o_rd, o_wr, o_done, o_err, o_busy;
  logic [31:0] o_addr;
  logic [63:0] o_wdata;
  logic [63:0] rdata;
  logic [63:0] pmem [0:1][0:15];
  logic [63:0] rmem [0:1][0:15];
  logic        pl_go;
  int          pl_w, pl_i;
  logic [63:0] pl_v;
  int          age;
  int          rd_idx;
  int          vectors;
  int          miscompares;

  store_merge_rmw_if #(.DATA_W(32), .ADDR_W(32)) bus_a ();
  store_merge_rmw_if #(.DATA_W(32), .ADDR_W(32)) bus_b ();
  store_merge_rmw_if #(.DATA_W(64), .ADDR_W(32)) bus_c ();

  store_merge_rmw #(.DATA_W(32), .ADDR_W(32), .RD_LAT(1)) u_a (.clk(clk), .reset(reset), .bus(bus_a));
  store_merge_rmw #(.DATA_W(32), .ADDR_W(32), .RD_LAT(3)) u_b (.clk(clk), .reset(reset), .bus(bus_b));
  store_merge_rmw #(.DATA_W(64), .ADDR_W(32), .RD_LAT(1)) u_c (.clk(clk), .reset(reset), .bus(bus_c));

  assign bus_a.req_valid = req_valid && (sel == 0);
  assign bus_a.req_addr  = req_addr;
  assign bus_a.req_data  = req_data[31:0];
  assign bus_a.req_size  = req_size;
  assign bus_a.mem_rdata = rdata[31:0];
  assign bus_b.req_valid = req_valid && (sel == 1);
  assign bus_b.req_addr  = req_addr;
  assign bus_b.req_data  = req_data[31:0];
  assign bus_b.req_size  = req_size;
  assign bus_b.mem_rdata = rdata[31:0];
  assign bus_c.req_valid = req_valid && (sel == 2);
  assign bus_c.req_addr  = req_addr;
  assign bus_c.req_data  = req_data;
  assign bus_c.req_size  = req_size;
  assign bus_c.mem_rdata = rdata;

  always #5 clk = ~clk;

  // Route the selected instance's outputs onto common observation signals.
  always_comb begin
    lat   = (sel == 1) ? 3 : 1;
    wsel  = (sel == 2) ? 1 : 0;
    shamt = (sel == 2) ? 3 : 2;
    case (sel)
      0: begin
        o_ready = bus_a.req_ready; o_rd = bus_a.mem_rd; o_wr = bus_a.mem_wr;
        o_done = bus_a.done; o_err = bus_a.err; o_busy = bus_a.busy;
        o_addr = bus_a.mem_addr; o_wdata = {32'h0, bus_a.mem_wdata};
      end
      1: begin
        o_ready = bus_b.req_ready; o_rd = bus_b.mem_rd; o_wr = bus_b.mem_wr;
        o_done = bus_b.done; o_err = bus_b.err; o_busy = bus_b.busy;
        o_addr = bus_b.mem_addr; o_wdata = {32'h0, bus_b.mem_wdata};
      end
      default: begin
        o_ready = bus_c.req_ready; o_rd = bus_c.mem_rd; o_wr = bus_c.mem_wr;
        o_done = bus_c.done; o_err = bus_c.err; o_busy = bus_c.busy;
        o_addr = bus_c.mem_addr; o_wdata = bus_c.mem_wdata;
      end
    endcase
  end

  // Memory: preload port, DUT write port and read-age tracking.
  always @(posedge clk) begin
    if (pl_go) begin
      pmem[pl_w][pl_i] <= pl_v;
    end else if (o_wr) begin
      pmem[wsel][int'((o_addr >> shamt) & 32'd15)] <= o_wdata;
    end
    if (o_rd) begin
      age    <= 1;
      rd_idx <= int'((o_addr >> shamt) & 32'd15);
    end else if (age != 0 && age < 15) begin
      age <= age + 1;
    end
  end

  // Read data is valid only in the cycle exactly RD_LAT cycles after mem_rd.
  always_comb begin
    if (age == lat) rdata = pmem[wsel][rd_idx];
    else            rdata = 64'hA5A5_5A5A_C3C3_3C3C;
  end

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input int w, input int i, input logic [63:0] v);
    pl_w = w; pl_i = i; pl_v = v; pl_go = 1'b1;
    rmem[w][i] = v;
    @(posedge clk);
    #1 pl_go = 1'b0;
  endtask

  // One store through the selected instance. All strobe timing and data are checked
  // against the reference model.
  task automatic run(input string tag, input int s, input logic [31:0] addr,
                     input logic [63:0] data_in, output logic [63:0] wd);
    int dw, nb, k, n, w, idx, t;
    int rd_c, wr_c, done_c, err_c, rdy_c, rd_n, wr_n, both, busy_bad;
    int e_rd, e_wr, e_done, e_err, e_rdy;
    bit legal, full;
    logic [63:0]  dmask, data, e_wd;
    logic [31:0]  rd_a, wr_a, e_addr;
    logic [127:0] m, merged;
    dw = (sel == 2) ? 64 : 32;
    nb = dw / 8;
    w  = (sel == 2) ? 1 : 0;
    dmask = (dw == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    data = data_in & dmask;
    k   = int'(addr % nb);
    idx = int'((addr / nb) % 16);
    n   = (s == 0) ? 4 : (s == 1) ? 2 : (s == 2) ? 1 : 8;
    legal = !(s == 3 && dw == 32) && (k % n == 0);
    full  = legal && (n == nb);
    e_addr = addr & ~(nb - 1);

    @(negedge clk);
    t = 0;
    while (!o_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    check_value({tag, "_ready_in"}, o_ready, 1);
    req_valid = 1'b1; req_addr = addr; req_data = data_in; req_size = s[1:0];
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_data  = {$urandom, $urandom};
    req_size  = 2'($urandom_range(3));

    rd_c = 0; wr_c = 0; done_c = 0; err_c = 0; rdy_c = 0;
    rd_n = 0; wr_n = 0; both = 0; busy_bad = 0;
    rd_a = 32'h0; wr_a = 32'h0; wd = 64'h0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (o_rd)   begin rd_n++; if (rd_c == 0) rd_c = c; rd_a = o_addr; end
      if (o_wr)   begin wr_n++; if (wr_c == 0) wr_c = c; wr_a = o_addr; wd = o_wdata; end
      if (o_done && done_c == 0) done_c = c;
      if (o_err && err_c == 0)   err_c = c;
      if (o_ready && rdy_c == 0) rdy_c = c;
      if (o_rd && o_wr) both++;
      if (o_busy == o_ready) busy_bad++;
    end

    e_rd   = (legal && !full) ? 1 : 0;
    e_wr   = !legal ? 0 : (full ? 1 : 2 + lat);
    e_done = legal ? e_wr + 1 : 0;
    e_err  = legal ? 0 : 1;
    e_rdy  = legal ? e_done + 1 : 2;
    m      = ((128'd1 << (8 * n)) - 128'd1) << (8 * k);
    merged = ({64'd0, rmem[w][idx]} & ~m) | (({64'd0, data} << (8 * k)) & m);
    e_wd   = merged[63:0] & dmask;

    check_value({tag, "_rd_cycle"},   rd_c, e_rd);
    check_value({tag, "_rd_count"},   rd_n, e_rd);
    check_value({tag, "_wr_cycle"},   wr_c, e_wr);
    check_value({tag, "_wr_count"},   wr_n, legal ? 1 : 0);
    check_value({tag, "_done_cycle"}, done_c, e_done);
    check_value({tag, "_err_cycle"},  err_c, e_err);
    check_value({tag, "_ready_cycle"}, rdy_c, e_rdy);
    check_value({tag, "_rd_addr"},    rd_a, (legal && !full) ? e_addr : 32'h0);
    check_value({tag, "_wr_addr"},    wr_a, legal ? e_addr : 32'h0);
    check_value({tag, "_rd_wr_overlap"}, both, 0);
    check_value({tag, "_busy_vs_ready"}, busy_bad, 0);
    if (legal) begin
      check_value({tag, "_wdata"}, wd, e_wd);
      rmem[w][idx] = e_wd;
    end
  endtask

  initial begin
    logic [63:0] wd;
    int s, off, rd_n, wr_n, dn_n, er_n, rdy_c;
    logic [31:0] a;
    clk = 1'b0; reset = 1'b0; sel = 0; req_valid = 1'b0; req_addr = 32'h0;
    req_data = 64'h0; req_size = 2'b00; pl_go = 1'b0; pl_w = 0; pl_i = 0; pl_v = 64'h0;
    age = 0; rd_idx = 0; vectors = 0; miscompares = 0;

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      sel = i;
      #1;
      check_value("rst_ready", o_ready, 0);
      check_value("rst_busy",  o_busy, 0);
      check_value("rst_rd",    o_rd, 0);
      check_value("rst_wr",    o_wr, 0);
      check_value("rst_done",  o_done, 0);
      check_value("rst_err",   o_err, 0);
      check_value("rst_addr",  o_addr, 0);
      check_value("rst_wdata", o_wdata, 0);
    end
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 16; i++) begin
        preload(w, i, (w == 1) ? {$urandom, $urandom} : {32'h0, $urandom});
      end
    end
    sel = 0;
    @(negedge clk);
    reset = 1'b1;
    #1 check_value("ready_before_edge", o_ready, 0);
    @(negedge clk);
    check_value("ready_after_edge", o_ready, 1);

    // Directed cases at 32-bit, RD_LAT=1.
    preload(0, 0, 64'hAABB_CCDD);
    run("byte_102", 2, 32'h102, 64'h11, wd);
    check_value("byte_102_val", wd, 64'hAA11_CCDD);
    preload(0, 0, 64'hAABB_CCDD);
    run("half_100", 1, 32'h100, 64'h1234, wd);
    check_value("half_100_val", wd, 64'hAABB_1234);
    preload(0, 0, 64'hAABB_CCDD);
    run("half_102", 1, 32'h102, 64'h5678, wd);
    check_value("half_102_val", wd, 64'h5678_CCDD);
    run("word_104", 0, 32'h104, 64'hDEAD_BEEF, wd);
    check_value("word_104_val", wd, 64'hDEAD_BEEF);
    run("err_half_101", 1, 32'h101, 64'h1, wd);
    run("err_word_102", 0, 32'h102, 64'h2, wd);
    run("err_full_32",  3, 32'h100, 64'h3, wd);

    // Longer read latency, then a reset during the wait phase.
    sel = 1;
    preload(0, 0, 64'hAABB_CCDD);
    run("lat3_byte_103", 2, 32'h103, 64'h77, wd);
    check_value("lat3_byte_103_val", wd, 64'h77BB_CCDD);
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h101; req_data = 64'h99; req_size = 2'b10;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check_value("abort_read", o_rd, 1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_value("abort_busy",  o_busy, 0);
    check_value("abort_ready", o_ready, 0);
    check_value("abort_wr",    o_wr, 0);
    @(negedge clk);
    reset = 1'b1;
    rd_n = 0; wr_n = 0; dn_n = 0; er_n = 0; rdy_c = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (o_rd) rd_n++;
      if (o_wr) wr_n++;
      if (o_done) dn_n++;
      if (o_err) er_n++;
      if (o_ready && rdy_c == 0) rdy_c = c;
    end
    check_value("abort_no_rd",   rd_n, 0);
    check_value("abort_no_wr",   wr_n, 0);
    check_value("abort_no_done", dn_n, 0);
    check_value("abort_no_err",  er_n, 0);
    check_value("abort_ready_cycle", rdy_c, 1);

    // 64-bit instance.
    sel = 2;
    preload(1, 0, 64'h0011_2233_4455_6677);
    run("w64_word_204", 0, 32'h204, 64'hCAFE_BABE, wd);
    check_value("w64_word_204_val", wd, 64'hCAFE_BABE_4455_6677);
    run("w64_full_200", 3, 32'h200, 64'h0123_4567_89AB_CDEF, wd);
    check_value("w64_full_200_val", wd, 64'h0123_4567_89AB_CDEF);
    run("w64_err_full_204", 3, 32'h204, 64'h5, wd);

    // Randomised stores on every configuration.
    for (int inst = 0; inst < 3; inst++) begin
      sel = inst;
      for (int r = 0; r < 30; r++) begin
        s   = $urandom_range(3);
        off = (inst == 2) ? $urandom_range(7) : $urandom_range(3);
        a   = ((inst == 2) ? 32'h200 : 32'h100)
            + 32'($urandom_range(15)) * ((inst == 2) ? 32'd8 : 32'd4) + 32'(off);
        run($sformatf("rnd%0d_%0d", inst, r), s, a, {$urandom, $urandom}, wd);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
